// File: rtl/bits_pkg.sv
// rtl/bits_pkg.sv - shared constants and types for the bit packer / unpacker pair
//
// Contents:
//   WORD_W, FIELD_W, LEN_W, NBITS_W : stream geometry shared with the unpacker
//   ACC_W, CNT_W, OCC_W             : packer-internal widths
//   fifo_entry_t                    : one queued output word {data, nbits}
//   field_mask()                    : low-order mask of lenin ones
package bits_pkg;

    localparam int WORD_W  = 32;
    localparam int FIELD_W = 15;
    localparam int LEN_W   = 4;
    localparam int NBITS_W = 6;

    // Up to 31 carried bits plus one 15-bit field.
    localparam int ACC_W   = WORD_W + FIELD_W;
    localparam int CNT_W   = 5;
    // Occupancy / free-slot width; covers 0..16.
    localparam int OCC_W   = 5;

    typedef struct packed {
        logic [WORD_W-1:0]  data;
        logic [NBITS_W-1:0] nbits;
    } fifo_entry_t;

    function automatic logic [FIELD_W-1:0] field_mask(input logic [LEN_W-1:0] len);
        return FIELD_W'((16'd1 << len) - 16'd1);
    endfunction

endpackage

// File: rtl/bits_pack_fifo.sv
// rtl/bits_pack_fifo.sv - output word queue with two write ports and one pop
//
// Ports:
//   clk, rst      : clock, async active-high reset
//   i_wr0_en/data : full-word write (ordered first)
//   i_wr1_en/data : flushed partial-word write (ordered second)
//   i_pop         : remove head entry (ignored when empty)
//   o_head        : head entry
//   o_empty       : queue empty
//   o_free        : free slots, DEPTH - occupancy
module bits_pack_fifo
    import bits_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr0_en,
    input  fifo_entry_t      i_wr0_data,
    input  logic             i_wr1_en,
    input  fifo_entry_t      i_wr1_data,
    input  logic             i_pop,
    output fifo_entry_t      o_head,
    output logic             o_empty,
    output logic [OCC_W-1:0] o_free
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [OCC_W-1:0] r_occ;

    logic [PTR_W-1:0] w_wptr1;
    logic [PTR_W-1:0] w_wptr2;
    logic [PTR_W-1:0] w_wptr_next;
    fifo_entry_t      w_first;
    logic [1:0]       w_nwr;
    logic             w_pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_wptr1     = ptr_inc(r_wptr);
        w_wptr2     = ptr_inc(w_wptr1);
        // A lone flush write still lands in the first free slot.
        w_first     = i_wr0_en ? i_wr0_data : i_wr1_data;
        w_nwr       = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};
        w_pop       = i_pop & ~o_empty;
        w_wptr_next = r_wptr;
        if (w_nwr == 2'd2) begin
            w_wptr_next = w_wptr2;
        end else if (w_nwr == 2'd1) begin
            w_wptr_next = w_wptr1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr0_en | i_wr1_en) begin
            r_mem[r_wptr] <= w_first;
        end
        if (i_wr0_en & i_wr1_en) begin
            r_mem[w_wptr1] <= i_wr1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            r_wptr <= w_wptr_next;
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_occ <= r_occ + OCC_W'(w_nwr) - OCC_W'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_occ == '0);
    assign o_free  = OCC_W'(DEPTH) - r_occ;

endmodule

// File: rtl/bits_pack.sv
// rtl/bits_pack.sv - packs 0..15-bit fields LSB-first into 32-bit words
//
// Ports:
//   clk, rst : clock, async active-high reset
//   pushin   : field valid; lenin = length, datain = field bits
//   flushin  : emit accumulated partial word (after any same-cycle push)
//   stopin   : downstream stall, no pop while high
//   stopout  : upstream stall, fewer than two free output slots
//   pushout  : one-cycle pulse per output word
//   dataout  : packed word, first bit at bit 0
//   nbits    : valid bits in dataout (32, or 1..31 when flushed)
module bits_pack
    import bits_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pushin,
    input  logic [LEN_W-1:0]   lenin,
    input  logic [FIELD_W-1:0] datain,
    input  logic               flushin,
    input  logic               stopin,
    output logic               stopout,
    output logic               pushout,
    output logic [WORD_W-1:0]  dataout,
    output logic [NBITS_W-1:0] nbits
);

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pushout;
    logic [WORD_W-1:0]  r_dataout;
    logic [NBITS_W-1:0] r_nbits;

    logic               w_push_ok;
    logic               w_flush_ok;
    logic [FIELD_W-1:0] w_masked;
    logic [ACC_W-1:0]   w_sum_acc;
    logic [CNT_W:0]     w_sum_cnt;
    logic               w_word_full;
    logic [ACC_W-1:0]   w_post_acc;
    logic [CNT_W-1:0]   w_post_cnt;
    logic               w_flush_word;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_cnt_next;
    fifo_entry_t        w_wr0_data;
    fifo_entry_t        w_wr1_data;
    fifo_entry_t        w_head;
    logic               w_empty;
    logic [OCC_W-1:0]   w_free;
    logic               w_pop;

    // Free slots come straight from the FIFO occupancy register, so stopout
    // has no path from any input. Two slots are kept because a push+flush
    // can write two entries in one cycle.
    assign stopout = (w_free < OCC_W'(2));

    always_comb begin
        w_push_ok  = pushin & ~stopout;
        w_flush_ok = flushin & ~stopout;
        w_masked   = datain & field_mask(lenin);

        w_sum_acc = r_acc;
        w_sum_cnt = {1'b0, r_cnt};
        if (w_push_ok) begin
            w_sum_acc = r_acc | (ACC_W'(w_masked) << r_cnt);
            w_sum_cnt = {1'b0, r_cnt} + (CNT_W + 1)'(lenin);
        end

        // Sum never exceeds 46, so bit 5 set means >= 32 and the low five
        // bits are already the count minus 32.
        w_word_full = w_sum_cnt[CNT_W];
        w_post_cnt  = w_sum_cnt[CNT_W-1:0];
        w_post_acc  = w_word_full ? (w_sum_acc >> WORD_W) : w_sum_acc;

        w_flush_word = w_flush_ok && (w_post_cnt != '0);

        w_acc_next = w_post_acc;
        w_cnt_next = w_post_cnt;
        if (w_flush_word) begin
            w_acc_next = '0;
            w_cnt_next = '0;
        end

        w_wr0_data.data  = w_sum_acc[WORD_W-1:0];
        w_wr0_data.nbits = NBITS_W'(WORD_W);
        // Bits above the count are always zero, so the partial word needs
        // no extra masking.
        w_wr1_data.data  = w_post_acc[WORD_W-1:0];
        w_wr1_data.nbits = {1'b0, w_post_cnt};

        w_pop = ~w_empty & ~stopin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
        end
    end

    bits_pack_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr0_en   (w_word_full),
        .i_wr0_data (w_wr0_data),
        .i_wr1_en   (w_flush_word),
        .i_wr1_data (w_wr1_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_free     (w_free)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pushout <= 1'b0;
            r_dataout <= '0;
            r_nbits   <= '0;
        end else begin
            r_pushout <= w_pop;
            if (w_pop) begin
                r_dataout <= w_head.data;
                r_nbits   <= w_head.nbits;
            end
        end
    end

    assign pushout = r_pushout;
    assign dataout = r_dataout;
    assign nbits   = r_nbits;

endmodule
